// File: rtl/mm_thread_pe.sv
// mm_thread_pe: one processing element of a matrix-multiply array. It owns a
// single output element C[FIX_ROW][FIX_COL]. While idle, it captures the
// matching row of A and column of B from a shared Din bus. On start_mm it
// streams both buffers through a signed multiply-accumulate and holds the dot
// product until it is acknowledged.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   a1, a2, a3           matrix shape: rows of A, inner dimension K, columns of B
//   start_mm             start the dot product (accepted only in IDLE and in range)
//   readA, readB         Din carries an element of A / B at (row, col)
//   row, col, Din        element index and data
//   ack_ticks            result acknowledge, DONE -> IDLE
//   acc                  accumulated result, stable while dp_done
//   dp_done              result valid (state DONE)
//   finished             element is outside the matrix or has its result
//   unused               element is outside the matrix
//   ovf                  sticky overflow, cleared by the next accepted start
module mm_thread_pe #(
    parameter int FIX_ROW = 6,
    parameter int FIX_COL = 8,
    parameter int DW      = 32,
    parameter int AW      = 4,
    parameter int ACC_W   = 32,
    parameter int SAT     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW:0]       a1,
    input  logic [AW:0]       a2,
    input  logic [AW:0]       a3,
    input  logic              start_mm,
    input  logic              readA,
    input  logic              readB,
    input  logic [AW:0]       row,
    input  logic [AW:0]       col,
    input  logic [DW-1:0]     Din,
    input  logic              ack_ticks,
    output logic [ACC_W-1:0]  acc,
    output logic              dp_done,
    output logic              finished,
    output logic              unused,
    output logic              ovf
);

    localparam int Depth = 2 ** AW;
    // Wide enough to hold the exact sum of the accumulator and a full product.
    localparam int SW = ((ACC_W > 2 * DW) ? ACC_W : 2 * DW) + 1;

    localparam logic [AW:0] FixRowW = (AW + 1)'(FIX_ROW);
    localparam logic [AW:0] FixColW = (AW + 1)'(FIX_COL);
    localparam logic [AW:0] KMax    = (AW + 1)'(Depth);

    localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [DW-1:0]           buf_a [Depth];
    logic [DW-1:0]           buf_b [Depth];
    logic [DW-1:0]           rd_a_q, rd_b_q;
    logic [AW-1:0]           rd_addr_q;
    logic                    rd_valid_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q;

    logic                    in_range;
    logic                    start_ok;
    logic                    we_a, we_b;
    logic [AW:0]             k_eff, k_last;
    logic                    last_rd;

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_t, sum_t;
    logic signed [SW-1:0]    sum_w;
    logic                    sum_fits, prod_fits, sum_ovf;

    assign in_range = (a1 > FixRowW) && (a3 > FixColW);
    assign unused   = ~in_range;
    assign finished = unused | dp_done;
    assign acc      = acc_q;
    assign ovf      = ovf_q;

    assign start_ok = (state_q == StIdle) && start_mm && in_range;

    assign we_a = (state_q == StIdle) && in_range && readA && (row == FixRowW);
    assign we_b = (state_q == StIdle) && in_range && readB && (col == FixColW);

    // Inner dimension beyond the buffer depth is clamped to the depth.
    assign k_eff   = (a2 > KMax) ? KMax : a2;
    assign k_last  = k_eff - 1'b1;
    assign last_rd = (rd_addr_q == k_last[AW-1:0]);

    // Buffers: no reset, contents survive a reset.
    always_ff @(posedge clk) begin
        if (we_a) buf_a[col[AW-1:0]] <= Din;
        if (we_b) buf_b[row[AW-1:0]] <= Din;
        rd_a_q <= buf_a[rd_addr_q];
        rd_b_q <= buf_b[rd_addr_q];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_mm && in_range) begin
                    state_d = (a2 == '0) ? StDone : StRun;
                end
            end
            StRun:   if (last_rd) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  if (ack_ticks) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        dp_done = (state_q == StDone);
    end

    // Multiply-accumulate. The exact sum is formed wide; the ACC_W result is
    // either its low bits (wrap) or a clamp toward the sign of the exact sum.
    always_comb begin
        prod      = $signed(rd_a_q) * $signed(rd_b_q);
        prod_t    = ACC_W'(prod);
        prod_fits = (SW'(prod_t) == SW'(prod));
        sum_w     = SW'(acc_q) + SW'(prod);
        sum_t     = ACC_W'(sum_w);
        sum_fits  = (SW'(sum_t) == sum_w);
        sum_ovf   = !sum_fits || !prod_fits;
        if (!sum_fits && (SAT != 0)) begin
            acc_d = sum_w[SW-1] ? AccMin : AccMax;
        end else begin
            acc_d = sum_t;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            // Read data lands one cycle after its address; valid follows it.
            rd_valid_q <= (state_q == StRun);
            if (state_q == StRun) begin
                rd_addr_q <= rd_addr_q + 1'b1;
            end else begin
                rd_addr_q <= '0;
            end
            if (start_ok) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (rd_valid_q) begin
                acc_q <= acc_d;
                if (sum_ovf) ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mm_thread_pe.sv
// Directed bench for mm_thread_pe. One default instance plus two 8-bit /
// 16-bit accumulator instances (saturating and wrapping) share all controls.
module tb_mm_thread_pe;

    logic        clk;
    logic        reset;
    logic [4:0]  a1, a2, a3, row, col;
    logic        start_mm, read_a, read_b, ack_ticks;
    logic [31:0] din;

    logic [31:0] acc;
    logic        dp_done, finished, unused, ovf;
    logic [15:0] acc_s, acc_w;
    logic        dp_done_s, finished_s, unused_s, ovf_s;
    logic        dp_done_w, finished_w, unused_w, ovf_w;

    int n_checks = 0;
    int n_errors = 0;

    mm_thread_pe u_dut (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .start_mm(start_mm),
        .readA(read_a), .readB(read_b), .row(row), .col(col), .Din(din),
        .ack_ticks(ack_ticks), .acc(acc), .dp_done(dp_done), .finished(finished),
        .unused(unused), .ovf(ovf)
    );

    mm_thread_pe #(.DW(8), .ACC_W(16), .SAT(1)) u_sat (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .start_mm(start_mm),
        .readA(read_a), .readB(read_b), .row(row), .col(col), .Din(din[7:0]),
        .ack_ticks(ack_ticks), .acc(acc_s), .dp_done(dp_done_s), .finished(finished_s),
        .unused(unused_s), .ovf(ovf_s)
    );

    mm_thread_pe #(.DW(8), .ACC_W(16), .SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .start_mm(start_mm),
        .readA(read_a), .readB(read_b), .row(row), .col(col), .Din(din[7:0]),
        .ack_ticks(ack_ticks), .acc(acc_w), .dp_done(dp_done_w), .finished(finished_w),
        .unused(unused_w), .ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input int idx, input logic [31:0] v);
        read_a = 1'b1; row = 5'd6; col = 5'(idx); din = v;
        tick();
        read_a = 1'b0;
    endtask

    task automatic load_b(input int idx, input logic [31:0] v);
        read_b = 1'b1; col = 5'd8; row = 5'(idx); din = v;
        tick();
        read_b = 1'b0;
    endtask

    task automatic ack();
        ack_ticks = 1'b1;
        tick();
        ack_ticks = 1'b0;
    endtask

    // Pulse start for one edge, then count edges until dp_done (bounded).
    task automatic start_and_wait(input int bound, output int n);
        start_mm = 1'b1;
        tick();
        start_mm = 1'b0;
        n = 0;
        while (dp_done == 1'b0 && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int seen;

        reset = 1'b1; a1 = 5'd7; a2 = 5'd3; a3 = 5'd9; row = '0; col = '0;
        start_mm = 1'b0; read_a = 1'b0; read_b = 1'b0; ack_ticks = 1'b0; din = '0;
        tick();
        tick();
        check("rst_acc", acc, 0);
        check("rst_dp_done", dp_done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_unused", unused, 0);
        check("rst_finished", finished, 0);
        reset = 1'b0;
        tick();

        // Out of range element
        a1 = 5'd6;
        #1;
        check("unused_a1", unused, 1);
        check("unused_finished", finished, 1);
        check("unused_acc", acc, 0);
        start_mm = 1'b1;
        tick();
        start_mm = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (dp_done) seen++;
            tick();
        end
        check("unused_no_done", seen, 0);
        a1 = 5'd7; a3 = 5'd8;
        #1;
        check("unused_a3", unused, 1);
        a3 = 5'd9;
        #1;
        check("in_range", unused, 0);

        // Basic: [1,2,3].[4,5,6] = 32; a write during RUN must be ignored
        for (int i = 0; i < 3; i++) begin
            load_a(i, 32'(i + 1));
            load_b(i, 32'(i + 4));
        end
        start_mm = 1'b1;
        tick();
        start_mm = 1'b0;
        tick();
        read_a = 1'b1; row = 5'd6; col = 5'd2; din = 32'd50;
        tick();
        read_a = 1'b0;
        n = 2;
        while (dp_done == 1'b0 && n < 64) begin
            tick();
            n++;
        end
        check("basic_latency", n, 4);
        check("basic_acc", acc, 32);
        check("basic_finished", finished, 1);
        check("basic_ovf", ovf, 0);
        ack();
        check("basic_ack", dp_done, 0);

        // Signed: [-2,3].[7,-1] = -17
        a2 = 5'd2;
        load_a(0, -32'sd2); load_a(1, 32'd3);
        load_b(0, 32'd7);   load_b(1, -32'sd1);
        start_and_wait(64, n);
        check("signed_latency", n, 3);
        check("signed_acc", acc, 32'hFFFF_FFEF);
        check("signed_ovf", ovf, 0);
        check("signed_acc16", acc_s, 16'hFFEF);
        ack();

        // Overflow: four products of 127*127 into a 16-bit accumulator
        a2 = 5'd4;
        for (int i = 0; i < 4; i++) begin
            load_a(i, 32'd127);
            load_b(i, 32'd127);
        end
        start_and_wait(64, n);
        check("sat_latency", n, 5);
        check("sat_acc", acc_s, 16'h7FFF);
        check("sat_ovf", ovf_s, 1);
        check("wrap_acc", acc_w, 16'hFC04);
        check("wrap_ovf", ovf_w, 1);
        check("wide_acc", acc, 32'd64516);
        check("wide_ovf", ovf, 0);
        ack();

        // K = 0 finishes on the accepting edge; start also clears ovf
        a2 = 5'd0;
        start_and_wait(0, n);
        check("k0_done", dp_done, 1);
        check("k0_acc", acc, 0);
        check("k0_ovf_clear", ovf_s, 0);
        start_mm = 1'b1; ack_ticks = 1'b1;
        tick();
        start_mm = 1'b0; ack_ticks = 1'b0;
        check("ack_wins", dp_done, 0);
        tick();
        check("no_restart", dp_done, 0);

        // K larger than the buffer depth is clamped to 16
        a2 = 5'd31;
        for (int i = 0; i < 16; i++) begin
            load_a(i, 32'd1);
            load_b(i, 32'(i + 1));
        end
        start_and_wait(40, n);
        check("clamp_latency", n, 17);
        check("clamp_acc", acc, 136);
        ack();

        // Reset during RUN aborts; buffers survive
        a2 = 5'd8;
        for (int i = 0; i < 8; i++) begin
            load_a(i, 32'(i + 1));
            load_b(i, 32'(i + 1));
        end
        start_mm = 1'b1;
        tick();
        start_mm = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("rst_run_acc", acc, 0);
        check("rst_run_done", dp_done, 0);
        tick();
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (dp_done) seen++;
            tick();
        end
        check("rst_run_idle", seen, 0);
        check("rst_run_acc_hold", acc, 0);
        start_and_wait(64, n);
        check("rerun_latency", n, 9);
        check("rerun_acc", acc, 204);
        ack();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
